// File: rtl/image_bank_scheduler_pkg.sv
// image_bank_scheduler_pkg: shared state encodings and default sizing for the bank scheduler.
package image_bank_scheduler_pkg;
    localparam int kDefaultImageAddressLength = 14;
    localparam int kDefaultNoOfPixels = 16384;
    typedef logic [1:0] acc_state_t;
    typedef logic [0:0] rd_state_t;
    localparam acc_state_t IDLE_S  = 2'd0;
    localparam acc_state_t KICK_S  = 2'd1;
    localparam acc_state_t ACCUM_S = 2'd2;
    localparam acc_state_t SWAP_S  = 2'd3;
    localparam rd_state_t RD_IDLE_S   = 1'b0;
    localparam rd_state_t RD_STREAM_S = 1'b1;
endpackage

// File: rtl/image_readout_stream.sv
// image_readout_stream: streams one bank's pixel addresses to the host with valid/ready.
module image_readout_stream
    import image_bank_scheduler_pkg::*;
#(
    parameter int kImageAddressLength = kDefaultImageAddressLength,
    parameter int kNoOfPixels = kDefaultNoOfPixels
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           start_bank,
    input  logic                           rd_ready,
    output logic                           rd_valid,
    output logic                           rd_bank,
    output logic [kImageAddressLength-1:0] rd_addr,
    output logic                           rd_last,
    output logic                           done
);
    localparam logic [kImageAddressLength-1:0] kLastAddr = kImageAddressLength'(kNoOfPixels - 1);
    rd_state_t state_q, state_d;
    logic bank_q, bank_d;
    logic [kImageAddressLength-1:0] addr_q, addr_d;
    assign rd_valid = state_q == RD_STREAM_S;
    assign rd_bank = bank_q;
    assign rd_addr = addr_q;
    assign rd_last = rd_valid && addr_q == kLastAddr;
    assign done = rd_last && rd_ready;
    always_comb begin
        state_d = state_q;
        bank_d = bank_q;
        addr_d = addr_q;
        if (state_q == RD_IDLE_S && start) begin
            state_d = RD_STREAM_S;
            bank_d = start_bank;
            addr_d = '0;
        end else if (done) begin
            state_d = RD_IDLE_S;
            addr_d = '0;
        end else if (rd_valid && rd_ready) begin
            addr_d = addr_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RD_IDLE_S;
            bank_q <= 1'b0;
            addr_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/image_bank_scheduler.sv
// image_bank_scheduler: ping-pong accumulation over two image banks with completion-order readout.
module image_bank_scheduler
    import image_bank_scheduler_pkg::*;
#(
    parameter int kImageAddressLength = kDefaultImageAddressLength,
    parameter int kNoOfPixels = kDefaultNoOfPixels
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           bp_start,
    output logic                           bp_start_ack,
    output logic                           ir_kick,
    input  logic                           ir_kick_ack,
    input  logic                           ir_done,
    output logic                           acc_bank,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic                           rd_bank,
    output logic [kImageAddressLength-1:0] rd_addr,
    output logic                           rd_last,
    output logic [1:0]                     full
);
    acc_state_t acc_state_q, acc_state_d;
    logic acc_bank_q, acc_bank_d, oldest_q, oldest_d, start_q, start_d, rd_done;
    logic [1:0] full_q, full_d, reading_q, reading_d;
    assign acc_bank = acc_bank_q;
    assign full = full_q;
    image_readout_stream #(
        .kImageAddressLength(kImageAddressLength),
        .kNoOfPixels(kNoOfPixels)
    ) u_readout (
        .clk(clk),
        .reset_n(reset_n),
        .start(start_q),
        .start_bank(oldest_q),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .rd_last(rd_last),
        .done(rd_done)
    );
    always_comb begin
        bp_start_ack = acc_state_q == IDLE_S && bp_start && !full_q[acc_bank_q] && !reading_q[acc_bank_q];
        ir_kick = acc_state_q == KICK_S;
        // readout only ever considers pre-swap full, so a coinciding swap is picked up next cycle
        start_d = !rd_valid && !start_q && full_q[oldest_q]
                  && !((acc_state_q == KICK_S || acc_state_q == ACCUM_S) && acc_bank_q == oldest_q);
        acc_state_d = acc_state_q == IDLE_S  ? (bp_start_ack ? KICK_S : IDLE_S) :
                      acc_state_q == KICK_S  ? (ir_kick_ack ? ACCUM_S : KICK_S) :
                      acc_state_q == ACCUM_S ? (ir_done ? SWAP_S : ACCUM_S) : IDLE_S;
        acc_bank_d = acc_bank_q;
        full_d = full_q;
        reading_d = reading_q;
        oldest_d = oldest_q;
        if (acc_state_q == SWAP_S) begin
            full_d[acc_bank_q] = 1'b1;
            oldest_d = full_q[~acc_bank_q] ? oldest_q : acc_bank_q;
            acc_bank_d = ~acc_bank_q;
        end
        if (start_d) reading_d[oldest_q] = 1'b1;
        if (rd_done) begin
            full_d[rd_bank] = 1'b0;
            reading_d[rd_bank] = 1'b0;
            oldest_d = ~rd_bank;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_state_q <= IDLE_S;
            acc_bank_q <= 1'b0;
            full_q <= '0;
            reading_q <= '0;
            oldest_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            acc_state_q <= acc_state_d;
            acc_bank_q <= acc_bank_d;
            full_q <= full_d;
            reading_q <= reading_d;
            oldest_q <= oldest_d;
            start_q <= start_d;
        end
    end
endmodule

// File: tb/tb_image_bank_scheduler.sv
// tb_image_bank_scheduler: scoreboard bench; completed images queue their expected beats in completion order.
module tb_image_bank_scheduler;
    localparam int AW = 8;
    localparam int NP = 200;
    logic clk = 0, reset_n = 0, bp_start = 0, ir_kick_ack = 0, ir_done = 0, rd_ready = 0;
    logic bp_start_ack, ir_kick, acc_bank, rd_valid, rd_bank, rd_last;
    logic [AW-1:0] rd_addr;
    logic [1:0] full;
    int n_chk = 0, n_fail = 0, rd_mode = 0;
    logic m_acc = 0;
    typedef struct {logic bank; int addr; logic last;} beat_t;
    beat_t exp_q[$];
    beat_t e_mon;
    logic prev_stall = 0, prev_bank = 0;
    logic [AW-1:0] prev_addr = 0;

    image_bank_scheduler #(.kImageAddressLength(AW), .kNoOfPixels(NP)) dut (
        .clk(clk), .reset_n(reset_n), .bp_start(bp_start), .bp_start_ack(bp_start_ack),
        .ir_kick(ir_kick), .ir_kick_ack(ir_kick_ack), .ir_done(ir_done), .acc_bank(acc_bank),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_last(rd_last), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 rd_ready = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
    end

    always @(negedge clk) begin
        if (!reset_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                check("stall_valid_held", rd_valid, 1);
                check("stall_addr_stable", rd_addr, prev_addr);
                check("stall_bank_stable", rd_bank, prev_bank);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got bank %0d addr %0d, expected no beat", rd_bank, rd_addr);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("rd_bank", rd_bank, e_mon.bank);
                    check("rd_addr", rd_addr, e_mon.addr);
                    check("rd_last", rd_last, e_mon.last);
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_addr = rd_addr;
            prev_bank = rd_bank;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_bp_start_ack"}, bp_start_ack, 0);
        check({tag, "_ir_kick"}, ir_kick, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_bank"}, rd_bank, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_acc_bank"}, acc_bank, 0);
    endtask

    task automatic start_image(input int budget, input bit chk_same);
        bit got = 0;
        int waited = 0;
        @(posedge clk);
        #1 bp_start = 1;
        while (!got && waited < budget) begin
            @(negedge clk);
            if (bp_start_ack) got = 1;
            else waited++;
        end
        check("bp_start_acked", got, 1);
        if (chk_same) check("ack_same_cycle", waited, 0);
        @(posedge clk);
        #1 bp_start = 0;
        if (!got) return;
        @(negedge clk);
        check("ir_kick_raised", ir_kick, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("ir_kick_until_ack", ir_kick, 1);
        @(posedge clk);
        #1 ir_kick_ack = 1;
        @(posedge clk);
        #1 ir_kick_ack = 0;
        @(negedge clk);
        check("ir_kick_dropped", ir_kick, 0);
    endtask

    task automatic finish_image(input int pre);
        repeat (pre) @(posedge clk);
        @(posedge clk);
        #1 ir_done = 1;
        for (int i = 0; i < NP; i++) exp_q.push_back('{m_acc, i, i == NP - 1});
        m_acc = ~m_acc;
        @(posedge clk);
        #1 ir_done = 0;
    endtask

    task automatic drain(input int budget);
        int w = 0;
        while ((exp_q.size() != 0 || full != 0) && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_full_clear", full, 0);
    endtask

    task automatic wait_addr(input int a, input int budget);
        bit found = 0;
        int w = 0;
        while (!found && w < budget) begin
            @(negedge clk);
            if (rd_valid && rd_ready && rd_addr == AW'(a)) found = 1;
            w++;
        end
        check("reached_addr", found, 1);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk);
        #1 ir_done = 1;
        @(posedge clk);
        #1 ir_done = 0;
        ir_kick_ack = 1;
        @(posedge clk);
        #1 ir_kick_ack = 0;
        repeat (3) @(negedge clk);
        check("spurious_full", full, 0);
        check("spurious_acc_bank", acc_bank, 0);
        check("spurious_kick", ir_kick, 0);
        // single image on bank 0, plus a stray kick ack during accumulation
        rd_mode = 1;
        start_image(50, 1);
        @(posedge clk);
        #1 ir_kick_ack = 1;
        @(posedge clk);
        #1 ir_kick_ack = 0;
        @(negedge clk);
        check("stray_ack_in_accum", ir_kick, 0);
        finish_image(2);
        @(negedge clk);
        @(negedge clk);
        check("single_full", full, 1);
        check("single_acc_bank", acc_bank, 1);
        drain(NP * 2 + 50);
        // one more image so both-full starts on bank 0
        start_image(50, 0);
        finish_image(1);
        drain(NP * 2 + 50);
        // both banks full with the host stalled
        rd_mode = 0;
        start_image(50, 0);
        finish_image($urandom_range(0, 5));
        start_image(50, 0);
        finish_image($urandom_range(0, 5));
        repeat (4) @(negedge clk);
        check("both_full", full, 3);
        check("both_acc_bank", acc_bank, 0);
        @(posedge clk);
        #1 bp_start = 1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bp_start_ack) cnt++;
        end
        check("no_ack_when_full", cnt, 0);
        rd_mode = 1;
        start_image(NP + 100, 0);
        finish_image($urandom_range(0, 5));
        drain(NP * 4);
        // random backpressure
        rd_mode = 2;
        repeat (3) begin
            start_image(NP * 4, 0);
            finish_image($urandom_range(0, 20));
        end
        drain(NP * 10);
        // bank 0 last beat coincides with bank 1 swap
        rd_mode = 0;
        start_image(50, 0);
        finish_image(1);
        start_image(50, 0);
        rd_mode = 1;
        wait_addr(NP - 3, NP * 2);
        finish_image(0);
        @(negedge clk);
        @(negedge clk);
        check("simul_full", full, 2);
        check("simul_acc_bank", acc_bank, 0);
        drain(NP * 2 + 50);
        // async reset mid-readout and mid-accumulation
        rd_mode = 0;
        start_image(50, 0);
        finish_image(1);
        start_image(50, 0);
        rd_mode = 1;
        wait_addr(100, NP * 2);
        #2 reset_n = 0;
        rd_mode = 0;
        #1 check_zero("mid_reset");
        exp_q.delete();
        m_acc = 0;
        @(posedge clk);
        #1 reset_n = 1;
        start_image(50, 1);
        finish_image(2);
        @(negedge clk);
        @(negedge clk);
        check("post_reset_full", full, 1);
        check("post_reset_acc_bank", acc_bank, 1);
        rd_mode = 1;
        drain(NP * 2 + 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected under 500000", $time);
        $fatal(1);
    end
endmodule
